// File: rtl/axil_reg_bridge_pkg.sv
// Shared types for the AXI4-Lite to register-port bridge.
// Response codes, FSM states and arbitration side.
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ISSUE,
    W_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ISSUE,
    R_RESP
  } rd_state_t;

  typedef enum logic {
    ARB_WRITE = 1'b0,
    ARB_READ  = 1'b1
  } arb_side_t;

  function automatic logic misaligned(
    input logic [1:0] lsb
  );
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/axil_reg_bridge_if.sv
// AXI4-Lite slave channels plus the register block's wr/rd port.
// slave = bridge side, master = bus master / register block side.
interface axil_reg_bridge_if #(
  parameter int AW = 4,
  parameter int DW = 32
);
  logic [AW-1:0]   s_awaddr;
  logic            s_awvalid;
  logic            s_awready;
  logic [DW-1:0]   s_wdata;
  logic [DW/8-1:0] s_wstrb;
  logic            s_wvalid;
  logic            s_wready;
  logic [1:0]      s_bresp;
  logic            s_bvalid;
  logic            s_bready;
  logic [AW-1:0]   s_araddr;
  logic            s_arvalid;
  logic            s_arready;
  logic [DW-1:0]   s_rdata;
  logic [1:0]      s_rresp;
  logic            s_rvalid;
  logic            s_rready;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            wr_en;
  logic            wr_ready;
  logic [AW-1:0]   rd_addr;
  logic            rd_en;
  logic [DW-1:0]   rd_data;
  logic            rd_valid;

  modport slave (
    input  s_awaddr, s_awvalid,
    input  s_wdata, s_wstrb, s_wvalid,
    input  s_bready,
    input  s_araddr, s_arvalid,
    input  s_rready,
    input  wr_ready, rd_data, rd_valid,
    output s_awready, s_wready,
    output s_bresp, s_bvalid,
    output s_arready,
    output s_rdata, s_rresp, s_rvalid,
    output wr_addr, wr_data, wr_en,
    output rd_addr, rd_en
  );

  modport master (
    output s_awaddr, s_awvalid,
    output s_wdata, s_wstrb, s_wvalid,
    output s_bready,
    output s_araddr, s_arvalid,
    output s_rready,
    output wr_ready, rd_data, rd_valid,
    input  s_awready, s_wready,
    input  s_bresp, s_bvalid,
    input  s_arready,
    input  s_rdata, s_rresp, s_rvalid,
    input  wr_addr, wr_data, wr_en,
    input  rd_addr, rd_en
  );

endinterface

// File: rtl/axil_reg_bridge_arb.sv
// Two-way round-robin grant for the shared register port.
// A read waiting on rd_valid keeps the port until its data arrives.
module reg_port_arb
  import axil_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_req_w,
  input  logic i_req_r,
  input  logic i_fire_w,
  input  logic i_fire_r,
  input  logic i_done_r,
  output logic o_gnt_w,
  output logic o_gnt_r
);

  arb_side_t r_last;
  logic      r_lock;
  logic      w_both;

  assign w_both  = i_req_w & i_req_r;
  assign o_gnt_r = i_req_r &
                   (r_lock | ~i_req_w |
                    (r_last == ARB_WRITE));
  assign o_gnt_w = i_req_w & ~o_gnt_r;

  // 'last' only moves when a contended grant is actually used
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= ARB_READ;
      r_lock <= 1'b0;
    end else begin
      r_lock <= i_fire_r & ~i_done_r;
      if (w_both & ~r_lock) begin
        if (i_fire_w)
          r_last <= ARB_WRITE;
        else if (i_fire_r)
          r_last <= ARB_READ;
      end
    end
  end

endmodule

// File: rtl/axil_reg_bridge.sv
// AXI4-Lite slave that sequences single-cycle accesses
// onto the timer register block's wr/rd port.
module axil_reg_bridge
  import axil_pkg::*;
#(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input logic              clk,
  input logic              rst,
  axil_reg_bridge_if.slave bus
);

  wr_state_t       r_wr_st, w_wr_nxt;
  rd_state_t       r_rd_st, w_rd_nxt;
  logic [AW-1:0]   r_awaddr, r_araddr;
  logic [DW-1:0]   r_wdata, r_rdata;
  logic [DW/8-1:0] r_wstrb;
  logic            r_aw_have, r_w_have;
  logic            r_awready, r_wready;
  logic            r_arready;
  resp_t           r_bresp, r_rresp;

  logic w_aw_hs, w_w_hs, w_ar_hs;
  logic w_b_hs, w_r_hs;
  logic w_aw_nxt, w_w_nxt;
  logic w_wr_err, w_rd_err;
  logic w_req_w, w_req_r;
  logic w_gnt_w, w_gnt_r;
  logic w_wr_en, w_rd_en, w_rd_done;

  assign w_aw_hs = bus.s_awvalid & r_awready;
  assign w_w_hs  = bus.s_wvalid & r_wready;
  assign w_ar_hs = bus.s_arvalid & r_arready;
  assign w_b_hs  = (r_wr_st == W_RESP) &
                   bus.s_bready;
  assign w_r_hs  = (r_rd_st == R_RESP) &
                   bus.s_rready;

  assign w_aw_nxt = ~w_b_hs &
                    (r_aw_have | w_aw_hs);
  assign w_w_nxt  = ~w_b_hs &
                    (r_w_have | w_w_hs);

  assign w_wr_err = misaligned(r_awaddr[1:0]) |
                    (r_wstrb != {(DW/8){1'b1}});
  assign w_rd_err = misaligned(r_araddr[1:0]);

  assign w_req_w = (r_wr_st == W_ISSUE) & ~w_wr_err;
  assign w_req_r = (r_rd_st == R_ISSUE) & ~w_rd_err;

  assign w_wr_en   = w_gnt_w & bus.wr_ready;
  assign w_rd_en   = w_gnt_r;
  assign w_rd_done = w_rd_en & bus.rd_valid;

  reg_port_arb u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_req_w  (w_req_w),
    .i_req_r  (w_req_r),
    .i_fire_w (w_wr_en),
    .i_fire_r (w_rd_en),
    .i_done_r (w_rd_done),
    .o_gnt_w  (w_gnt_w),
    .o_gnt_r  (w_gnt_r)
  );

  always_comb begin
    w_wr_nxt = r_wr_st;
    unique case (r_wr_st)
      W_IDLE:
        if (w_aw_nxt & w_w_nxt)
          w_wr_nxt = W_ISSUE;
      W_ISSUE:
        if (w_wr_err | w_wr_en)
          w_wr_nxt = W_RESP;
      W_RESP:
        if (bus.s_bready)
          w_wr_nxt = W_IDLE;
      default:
        w_wr_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_rd_nxt = r_rd_st;
    unique case (r_rd_st)
      R_IDLE:
        if (w_ar_hs)
          w_rd_nxt = R_ISSUE;
      R_ISSUE:
        if (w_rd_err | w_rd_done)
          w_rd_nxt = R_RESP;
      R_RESP:
        if (bus.s_rready)
          w_rd_nxt = R_IDLE;
      default:
        w_rd_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_st <= W_IDLE;
      r_rd_st <= R_IDLE;
    end else begin
      r_wr_st <= w_wr_nxt;
      r_rd_st <= w_rd_nxt;
    end
  end

  // readies are recomputed from the next-cycle view of the capture state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_aw_have <= 1'b0;
      r_w_have  <= 1'b0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bresp   <= OKAY;
    end else begin
      if (w_aw_hs)
        r_awaddr <= bus.s_awaddr;
      if (w_w_hs) begin
        r_wdata <= bus.s_wdata;
        r_wstrb <= bus.s_wstrb;
      end
      r_aw_have <= w_aw_nxt;
      r_w_have  <= w_w_nxt;
      r_awready <= ~w_aw_nxt &
                   (w_wr_nxt == W_IDLE);
      r_wready  <= ~w_w_nxt &
                   (w_wr_nxt == W_IDLE);
      if (r_wr_st == W_ISSUE) begin
        if (w_wr_err)
          r_bresp <= SLVERR;
        else if (w_wr_en)
          r_bresp <= OKAY;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_araddr  <= '0;
      r_arready <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= OKAY;
    end else begin
      if (w_ar_hs)
        r_araddr <= bus.s_araddr;
      r_arready <= (w_rd_nxt == R_IDLE);
      if (r_rd_st == R_ISSUE) begin
        if (w_rd_err) begin
          r_rdata <= '0;
          r_rresp <= SLVERR;
        end else if (w_rd_done) begin
          r_rdata <= bus.rd_data;
          r_rresp <= OKAY;
        end
      end
    end
  end

  assign bus.s_awready = r_awready;
  assign bus.s_wready  = r_wready;
  assign bus.s_arready = r_arready;
  assign bus.s_bvalid  = (r_wr_st == W_RESP);
  assign bus.s_bresp   = r_bresp;
  assign bus.s_rvalid  = (r_rd_st == R_RESP);
  assign bus.s_rresp   = r_rresp;
  assign bus.s_rdata   = r_rdata;
  assign bus.wr_addr   = r_awaddr;
  assign bus.wr_data   = r_wdata;
  assign bus.wr_en     = w_wr_en;
  assign bus.rd_addr   = r_araddr;
  assign bus.rd_en     = w_rd_en;

  logic w_unused;
  assign w_unused = w_r_hs;

endmodule
